// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, parity constants and sampling helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Two-of-three vote used when the line is sampled over a short window.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_baud_counter.sv
// rtl/uart_rx_baud_counter.sv - bit-period counter producing half- or full-bit sample ticks
module uart_rx_baud_counter #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic i_clock,
  input  logic i_resetL,
  input  logic clear,
  input  logic half_sel,
  output logic tick
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // The tick marks the sample point; the counter wraps on it so the next bit is timed from here.
  assign tick = !clear && (cnt == (half_sel ? HALF_LAST : FULL_LAST));

  // Count clock cycles within the current (half) bit period; held at zero while cleared.
  always_ff @(posedge i_clock) begin
    if (!i_resetL || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with held-frame output register (optional macro RX_MAJORITY_VOTE_EN)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t state, state_next;

  logic rx_meta, rx_s;
  logic sample;
  logic tick;
  logic cnt_clear;
  logic half_sel;

  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic                  par_bit;
  logic                  ferr_acc;

  logic last_data, last_stop, commit;
  logic data_par, perr_new, ferr_new;

  // Bring the asynchronous line into the clock domain; idles high out of reset.
  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_s    <= rx_meta;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic rx_d1, rx_d2;

  // Keep the two previous synchronized values so each sample votes over three cycles.
  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign sample = majority3(rx_d2, rx_d1, rx_s);
`else
  assign sample = rx_s;
`endif

  uart_rx_baud_counter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud (
    .i_clock (i_clock),
    .i_resetL(i_resetL),
    .clear   (cnt_clear),
    .half_sel(half_sel),
    .tick    (tick)
  );

  assign last_data = (bit_cnt == DATA_LAST);
  assign last_stop = (bit_cnt == STOP_LAST);
  assign commit    = (state == ST_STOP) && tick && last_stop;

  assign data_par = (^shreg) ^ par_bit;
  assign perr_new = (PARITY_MODE == PARITY_EVEN) ? data_par :
                    (PARITY_MODE == PARITY_ODD)  ? !data_par : 1'b0;
  assign ferr_new = ferr_acc | !sample;

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing: start qualification, data bits, optional parity, stop bits.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_next = ST_START;
      ST_START:  if (tick) state_next = sample ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && last_data)
                   state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_next = ST_STOP;
      ST_STOP:   if (tick && last_stop) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State decodes: busy flag and bit-period counter control.
  always_comb begin
    o_busy    = (state != ST_IDLE);
    cnt_clear = (state == ST_IDLE);
    half_sel  = (state == ST_START);
  end

  // Per-frame datapath: shift data LSB-first, capture parity, accumulate stop errors.
  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_START: begin
          bit_cnt  <= '0;
          ferr_acc <= 1'b0;
        end
        ST_DATA: begin
          shreg   <= {sample, shreg[DATA_WIDTH-1:1]};
          bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
        end
        ST_PARITY: begin
          par_bit <= sample;
        end
        ST_STOP: begin
          ferr_acc <= ferr_new;
          bit_cnt  <= bit_cnt + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Held-frame register: load on commit when free or being drained, else drop and flag overrun.
  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (commit && (!o_valid || i_ready)) begin
        o_valid      <= 1'b1;
        o_data       <= shreg;
        o_parity_err <= perr_new;
        o_frame_err  <= ferr_new;
      end else begin
        if (commit) begin
          o_overrun <= 1'b1;
        end
        if (o_valid && i_ready) begin
          o_valid <= 1'b0;
        end
      end
    end
  end

endmodule
